// File: rtl/sigmeter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sigmeter_pkg
// Description : Shared types and helpers for the multi-channel signal meter.
//               - sigmeter_state_e  : result streaming FSM states
//               - sigmeter_result_t : one channel's measurement result
//               - reset_threshold() : mid-scale crossing threshold after reset
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sigmeter_pkg;

    // Widths of the result record. The meter's DATA_W / FREQ_W parameters
    // must match these; the top level refuses to elaborate otherwise.
    localparam int c_RESULT_DATA_W = 12;
    localparam int c_RESULT_FREQ_W = 32;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DUMP  = 1'b1
    } sigmeter_state_e;

    typedef struct packed {
        logic [c_RESULT_DATA_W-1:0] vpp;
        logic [c_RESULT_DATA_W-1:0] offset;
        logic [c_RESULT_FREQ_W-1:0] freq;
        logic                       no_signal;
    } sigmeter_result_t;

    // Mid-scale code 2^(data_w-1); callers truncate to their own width.
    function automatic logic [31:0] reset_threshold(input int data_w);
        return 32'd1 << (data_w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sigmeter_chan.sv
`default_nettype none
// ============================================================================
// Module      : sigmeter_chan
// Description : One measurement channel: min/max, threshold crossing count,
//               adaptive threshold and the result snapshot taken at gate end.
//               Optional hysteresis on the crossing detector when the macro
//               SIGMETER_HYST_EN is defined.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_sample_valid     - sample for this channel this cycle
//               i_sample_data      - ADC code
//               i_gate_tick        - gate end strobe
//               o_live             - result computed from current accumulators
//               o_snap             - result captured at the last gate end
// Revision    : 1.0 - initial release
// ============================================================================
module sigmeter_chan
    import sigmeter_pkg::*;
#(
    parameter int DATA_W = c_RESULT_DATA_W,
    parameter int FREQ_W = c_RESULT_FREQ_W,
    parameter int HYST   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_sample_data,
    input  logic              i_gate_tick,
    output sigmeter_result_t  o_live,
    output sigmeter_result_t  o_snap
);

    localparam logic [DATA_W-1:0] c_THR_RESET = DATA_W'(reset_threshold(DATA_W));
    localparam logic [DATA_W-1:0] c_ALL_ONES  = '1;
    localparam logic [FREQ_W-1:0] c_CNT_MAX   = '1;

    if (HYST < 0) begin : g_hyst_check
        $error("sigmeter_chan: HYST must be non-negative");
    end

    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_thr;
    logic [FREQ_W-1:0] r_count;
    logic              r_seen;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_thr_use;
    logic [DATA_W-1:0] w_min_base;
    logic [DATA_W-1:0] w_max_base;
    logic [FREQ_W-1:0] w_cnt_base;
    logic              w_seen_base;
    logic              w_cross;

    // One extra bit so max+min cannot wrap before halving.
    assign w_sum = {1'b0, r_max} + {1'b0, r_min};

    always_comb begin
        o_live.no_signal = ~r_seen;
        if (r_seen) begin
            o_live.vpp    = r_max - r_min;
            o_live.offset = w_sum[DATA_W:1];
            o_live.freq   = r_count;
        end else begin
            o_live.vpp    = '0;
            o_live.offset = r_thr;
            o_live.freq   = '0;
        end
    end

    // At gate end the new threshold is exactly the snapshot offset (which
    // already falls back to the held threshold for an idle channel). A sample
    // landing on the gate end cycle belongs to the new gate, so it is judged
    // against the new threshold and folded into freshly cleared accumulators.
    assign w_thr_use   = i_gate_tick ? o_live.offset : r_thr;
    assign w_min_base  = i_gate_tick ? c_ALL_ONES : r_min;
    assign w_max_base  = i_gate_tick ? '0 : r_max;
    assign w_cnt_base  = i_gate_tick ? '0 : r_count;
    assign w_seen_base = i_gate_tick ? 1'b0 : r_seen;

`ifdef SIGMETER_HYST_EN
    localparam logic [DATA_W:0] c_HYST = (DATA_W+1)'(HYST);

    logic [DATA_W:0]   w_lo_ext;
    logic [DATA_W:0]   w_hi_ext;
    logic [DATA_W-1:0] w_thr_lo;
    logic [DATA_W-1:0] w_thr_hi;
    logic              r_armed;

    // Borrow/carry out of the extended width selects the clamp value.
    assign w_lo_ext = {1'b0, w_thr_use} - c_HYST;
    assign w_hi_ext = {1'b0, w_thr_use} + c_HYST;
    assign w_thr_lo = w_lo_ext[DATA_W] ? '0 : w_lo_ext[DATA_W-1:0];
    assign w_thr_hi = w_hi_ext[DATA_W] ? c_ALL_ONES : w_hi_ext[DATA_W-1:0];

    assign w_cross = i_sample_valid && r_armed && (i_sample_data > w_thr_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (i_sample_valid) begin
            if (w_cross) begin
                r_armed <= 1'b0;
            end else if (i_sample_data < w_thr_lo) begin
                r_armed <= 1'b1;
            end
        end
    end
`else
    logic w_above;
    logic r_above;

    assign w_above = (i_sample_data >= w_thr_use);
    assign w_cross = i_sample_valid && w_above && !r_above;

    // Previous-above state survives gate boundaries so an edge straddling
    // the gate end is counted exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_above <= 1'b0;
        end else if (i_sample_valid) begin
            r_above <= w_above;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min   <= c_ALL_ONES;
            r_max   <= '0;
            r_count <= '0;
            r_seen  <= 1'b0;
            r_thr   <= c_THR_RESET;
            o_snap  <= '0;
        end else begin
            if (i_gate_tick) begin
                o_snap <= o_live;
                r_thr  <= w_thr_use;
            end
            r_seen  <= w_seen_base | i_sample_valid;
            r_min   <= (i_sample_valid && (i_sample_data < w_min_base)) ? i_sample_data : w_min_base;
            r_max   <= (i_sample_valid && (i_sample_data > w_max_base)) ? i_sample_data : w_max_base;
            r_count <= (w_cross && (w_cnt_base != c_CNT_MAX)) ? (w_cnt_base + FREQ_W'(1)) : w_cnt_base;
        end
    end

endmodule
`default_nettype wire

// File: rtl/signal_meter_mc.sv
`default_nettype none
// ============================================================================
// Module      : signal_meter_mc
// Description : Multi-channel measurement engine. Per channel and per gate
//               window it measures peak-to-peak, midpoint offset and rising
//               threshold crossings, then streams one result per channel.
//               Define SIGMETER_HYST_EN to add hysteresis to crossing
//               detection.
// Ports       : clock, reset  - clock, synchronous active-high reset
//               sample_valid / sample_ch / sample_data - ADC sample input
//               result_valid  - one-cycle strobe per channel result
//               result_ch, vpp, offset, freq, no_signal - result fields
//               gate_tick     - one-cycle strobe at gate end
// Revision    : 1.0 - initial release
// ============================================================================
module signal_meter_mc
    import sigmeter_pkg::*;
#(
    parameter int DATA_W      = c_RESULT_DATA_W,
    parameter int NUM_CH      = 2,
    parameter int CH_W        = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int FREQ_W      = c_RESULT_FREQ_W,
    parameter int HYST        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [CH_W-1:0]   sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    output logic              result_valid,
    output logic [CH_W-1:0]   result_ch,
    output logic [DATA_W-1:0] vpp,
    output logic [DATA_W-1:0] offset,
    output logic [FREQ_W-1:0] freq,
    output logic              no_signal,
    output logic              gate_tick
);

    localparam int              c_GATE_W     = ($clog2(GATE_CYCLES) > 0) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
    localparam logic [CH_W:0]   c_NUM_CH_IDX = (CH_W+1)'(NUM_CH);

    if (GATE_CYCLES <= NUM_CH + 1) begin : g_gate_check
        $error("signal_meter_mc: GATE_CYCLES must exceed NUM_CH+1");
    end
    if ((DATA_W != c_RESULT_DATA_W) || (FREQ_W != c_RESULT_FREQ_W)) begin : g_width_check
        $error("signal_meter_mc: DATA_W/FREQ_W must match sigmeter_pkg result widths");
    end

    logic [c_GATE_W-1:0] r_gate_cnt;
    logic [NUM_CH-1:0]   w_ch_valid;
    sigmeter_result_t    w_live [NUM_CH];
    sigmeter_result_t    w_snap [NUM_CH];
    sigmeter_state_e     r_state;
    sigmeter_state_e     w_state_nxt;
    logic [CH_W:0]       r_ch_idx;
    logic [CH_W:0]       w_ch_idx_nxt;
    logic [CH_W:0]       w_emit_idx;
    logic                w_emit;
    sigmeter_result_t    w_src;

    assign gate_tick = (r_gate_cnt == c_GATE_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gate_cnt <= '0;
        end else if (gate_tick) begin
            r_gate_cnt <= '0;
        end else begin
            r_gate_cnt <= r_gate_cnt + c_GATE_W'(1);
        end
    end

    // Out-of-range channel codes match no decoder and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        localparam logic [CH_W-1:0] c_IDX = CH_W'(g);

        assign w_ch_valid[g] = sample_valid && (sample_ch == c_IDX);

        sigmeter_chan #(
            .DATA_W (DATA_W),
            .FREQ_W (FREQ_W),
            .HYST   (HYST)
        ) u_chan (
            .clk            (clock),
            .rst            (reset),
            .i_sample_valid (w_ch_valid[g]),
            .i_sample_data  (sample_data),
            .i_gate_tick    (gate_tick),
            .o_live         (w_live[g]),
            .o_snap         (w_snap[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_ACCUM;
            r_ch_idx <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ch_idx <= w_ch_idx_nxt;
        end
    end

    // Channel 0 is emitted on the gate end edge itself, straight from the
    // live accumulators (identical to what the snapshot captures on that
    // edge); the rest come from the snapshot bank, one per cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_ch_idx_nxt = r_ch_idx;
        w_emit       = 1'b0;
        w_emit_idx   = r_ch_idx;
        case (r_state)
            ST_ACCUM: begin
                w_emit_idx = '0;
                if (gate_tick) begin
                    w_emit       = 1'b1;
                    w_state_nxt  = ST_DUMP;
                    w_ch_idx_nxt = (CH_W+1)'(1);
                end
            end
            ST_DUMP: begin
                if (r_ch_idx < c_NUM_CH_IDX) begin
                    w_emit       = 1'b1;
                    w_ch_idx_nxt = r_ch_idx + (CH_W+1)'(1);
                end else begin
                    w_state_nxt  = ST_ACCUM;
                    w_ch_idx_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = ST_ACCUM;
                w_ch_idx_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_src = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_emit_idx == (CH_W+1)'(i)) begin
                w_src = (r_state == ST_ACCUM) ? w_live[i] : w_snap[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result_valid <= 1'b0;
            result_ch    <= '0;
            vpp          <= '0;
            offset       <= '0;
            freq         <= '0;
            no_signal    <= 1'b0;
        end else begin
            result_valid <= w_emit;
            if (w_emit) begin
                result_ch <= w_emit_idx[CH_W-1:0];
                vpp       <= w_src.vpp;
                offset    <= w_src.offset;
                freq      <= w_src.freq;
                no_signal <= w_src.no_signal;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_signal_meter_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_signal_meter_mc
// Description : Self-checking bench for signal_meter_mc. Random and directed
//               sample streams are compared against a queue-based reference
//               model that evaluates each gate from its stored sample list.
//               Build with SIGMETER_HYST_EN to exercise hysteresis.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_meter_mc;

    localparam int DATA_W      = 12;
    localparam int NUM_CH      = 2;
    localparam int CH_W        = 2;
    localparam int GATE_CYCLES = 1000;
    localparam int FREQ_W      = 32;
    localparam int HYST        = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              sample_valid = 1'b0;
    logic [CH_W-1:0]   sample_ch = '0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              result_valid;
    logic [CH_W-1:0]   result_ch;
    logic [DATA_W-1:0] vpp;
    logic [DATA_W-1:0] offset;
    logic [FREQ_W-1:0] freq;
    logic              no_signal;
    logic              gate_tick;

    always #5 clock = ~clock;

    signal_meter_mc #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .GATE_CYCLES (GATE_CYCLES),
        .FREQ_W      (FREQ_W),
        .HYST        (HYST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .vpp          (vpp),
        .offset       (offset),
        .freq         (freq),
        .no_signal    (no_signal),
        .gate_tick    (gate_tick)
    );

    typedef struct {
        int unsigned ch;
        int unsigned vpp;
        int unsigned offset;
        int unsigned freq;
        bit          ns;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int unsigned m_pos;
    int unsigned m_thr   [NUM_CH];
    bit          m_prev  [NUM_CH];
    bit          m_armed [NUM_CH];
    int unsigned m_samp  [NUM_CH][$];
    res_t        m_exp[$];
    res_t        m_last;

    // Last result observed from the DUT per channel
    int unsigned cap_vpp  [NUM_CH];
    int unsigned cap_off  [NUM_CH];
    int unsigned cap_freq [NUM_CH];
    int unsigned cap_ns   [NUM_CH];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pos = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_thr[c]   = 2048;
            m_prev[c]  = 1'b0;
            m_armed[c] = 1'b0;
            m_samp[c].delete();
        end
        m_exp.delete();
        m_last = '{default: 0};
    endfunction

    // Evaluate every channel's finished gate from its sample list.
    function automatic void model_gate_end();
        for (int c = 0; c < NUM_CH; c++) begin
            res_t r;
            r.ch = c;
            if (m_samp[c].size() == 0) begin
                r.vpp = 0; r.offset = m_thr[c]; r.freq = 0; r.ns = 1'b1;
            end else begin
                int unsigned mn = m_samp[c][0];
                int unsigned mx = m_samp[c][0];
                int unsigned cnt = 0;
                foreach (m_samp[c][i]) begin
                    int unsigned x = m_samp[c][i];
                    if (x < mn) mn = x;
                    if (x > mx) mx = x;
`ifdef SIGMETER_HYST_EN
                    begin
                        int unsigned lo = (m_thr[c] > HYST) ? m_thr[c] - HYST : 0;
                        int unsigned hi = (m_thr[c] + HYST > 4095) ? 4095 : m_thr[c] + HYST;
                        if (m_armed[c] && x > hi) begin
                            cnt++;
                            m_armed[c] = 1'b0;
                        end else if (x < lo) begin
                            m_armed[c] = 1'b1;
                        end
                    end
`else
                    if (x >= m_thr[c] && !m_prev[c]) cnt++;
                    m_prev[c] = (x >= m_thr[c]);
`endif
                end
                r.vpp = mx - mn; r.offset = (mx + mn) / 2; r.freq = cnt; r.ns = 1'b0;
                m_thr[c] = r.offset;
            end
            m_exp.push_back(r);
            m_samp[c].delete();
        end
    endfunction

    task automatic step(input bit rst_i, input bit v, input int unsigned ch, input int unsigned d);
        check("gate_tick", gate_tick, (m_pos == GATE_CYCLES - 1));
        reset        = rst_i;
        sample_valid = v;
        sample_ch    = ch[CH_W-1:0];
        sample_data  = d[DATA_W-1:0];
        if (rst_i) begin
            model_reset();
        end else begin
            if (m_pos == GATE_CYCLES - 1) model_gate_end();
            if (v && ch < NUM_CH) m_samp[ch].push_back(d);
            m_pos = (m_pos + 1) % GATE_CYCLES;
        end
        @(posedge clock);
        @(negedge clock);
        if (m_exp.size() > 0) begin
            m_last = m_exp.pop_front();
            check("result_valid", result_valid, 1);
        end else begin
            check("result_valid", result_valid, 0);
        end
        check("result_ch", result_ch, m_last.ch);
        check("vpp", vpp, m_last.vpp);
        check("offset", offset, m_last.offset);
        check("freq", freq, m_last.freq);
        check("no_signal", no_signal, m_last.ns);
        if (result_valid === 1'b1 && result_ch < NUM_CH) begin
            cap_vpp[result_ch]  = vpp;
            cap_off[result_ch]  = offset;
            cap_freq[result_ch] = freq;
            cap_ns[result_ch]   = no_signal;
        end
    endtask

    function automatic int unsigned sq_a(input int unsigned t);
        return ((t / 50) % 2) ? 3000 : 1000;
    endfunction

    // Square 1096/3000 (midpoint 2048) with alternating 2038/2058 codes at
    // each level change.
    function automatic int unsigned sq_d(input int unsigned t);
        int unsigned p = t % 100;
        if (p < 5 || (p >= 50 && p < 55)) return (p % 2) ? 2058 : 2038;
        if (p < 50) return 1096;
        return 3000;
    endfunction

    task automatic rand_step(input int unsigned t);
        int unsigned r = $urandom_range(0, 9);
        if (r == 0)
            step(0, 0, 0, $urandom_range(0, 4095));
        else if (r == 1)
            step(0, 1, 3, 4095);
        else if (r <= 5)
            step(0, 1, 0, (((t / 40) % 2) ? 3500 : 500) + $urandom_range(0, 40));
        else
            step(0, 1, 1, 200 + (t % 130) * 12 + $urandom_range(0, 20));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit edge_done;
        bit seen0;
        int guard;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        model_reset();
        reset = 1'b0;
        check("reset result_valid", result_valid, 0);
        check("reset vpp", vpp, 0);
        check("reset freq", freq, 0);
        check("reset gate_tick", gate_tick, 0);

        // Square on ch0 only for two full gates
        for (int t = 0; t < 2100; t++) step(0, 1, 0, sq_a(t));
        check("A ch0 vpp", cap_vpp[0], 2000);
        check("A ch0 offset", cap_off[0], 2000);
        check("A ch0 freq", cap_freq[0], 10);
        check("A ch1 no_signal", cap_ns[1], 1);
        check("A ch1 freq", cap_freq[1], 0);
        check("A ch1 offset", cap_off[1], 2048);

        // Interleaved random traffic, invalid channel codes, and an extreme
        // sample placed exactly on a gate end cycle
        edge_done = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (!edge_done && m_pos == GATE_CYCLES - 1) begin
                step(0, 1, 0, 4095);
                edge_done = 1'b1;
            end else begin
                rand_step(t);
            end
        end

        // Reset right after the first strobe of a dump
        seen0 = 1'b0;
        guard = 0;
        while (!seen0 && guard < 1200) begin
            rand_step(guard);
            guard++;
            if (result_valid === 1'b1 && result_ch == 0) seen0 = 1'b1;
        end
        check("dump start seen", seen0, 1);
        step(1, 0, 0, 0);
        check("post-reset result_valid", result_valid, 0);
        check("post-reset vpp", vpp, 0);

        // Noisy square around the reset threshold
        for (int t = 0; t < 1100; t++) step(0, 1, 0, sq_d(t));
`ifdef SIGMETER_HYST_EN
        check("D hyst freq", cap_freq[0], 10);
`else
        check("D noisy freq above 10", (cap_freq[0] > 10), 1);
`endif
        check("D ch0 offset", cap_off[0], 2048);
        check("D ch0 vpp", cap_vpp[0], 1904);
        check("D ch1 threshold after reset", cap_off[1], 2048);
        check("D ch1 no_signal", cap_ns[1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
